// File: rtl/fmdsp_pkg.sv
// Shared definitions for the FMDSP multiplier datapath: pipeline limits,
// Wallace-tree row bookkeeping and the register-placement mask used by
// pp_reduction (and by anything that needs to predict its latency).
package fmdsp_pkg;

    localparam int MAX_PIPES  = 4;
    localparam int MAX_LEVELS = 6;   // WIDTH=16 needs six reduction levels

    // Rows left after one level of 3:2 counters: each full group of three
    // becomes two, leftovers pass straight through.
    function automatic int rows_after(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    // Row count at the input of reduction level lvl (0-based).
    function automatic int rows_at(input int width, input int lvl);
        int n;
        n = width;
        for (int i = 0; i < lvl; i++) begin
            n = rows_after(n);
        end
        return n;
    endfunction

    // Number of 3:2 levels needed to bring WIDTH rows down to two.
    function automatic int num_levels(input int width);
        int n;
        int l;
        n = width;
        l = 0;
        while (n > 2) begin
            n = rows_after(n);
            l++;
        end
        return l;
    endfunction

    // Bit offset of level boundary lvl inside the flattened row bus.
    function automatic int bus_offset(input int width, input int lvl);
        int off;
        off = 0;
        for (int i = 0; i < lvl; i++) begin
            off += rows_at(width, i) * 2 * width;
        end
        return off;
    endfunction

    // Bit j-1 set when level j is registered for k register levels: the k
    // registers are spread evenly, level = round(i*NUM_LEVELS/k), i=1..k.
    function automatic logic [MAX_LEVELS-1:0] level_reg_mask(input int width, input int k);
        logic [MAX_LEVELS-1:0] m;
        int nl;
        int kk;
        int pos;
        m  = '0;
        nl = num_levels(width);
        kk = (k > MAX_PIPES) ? MAX_PIPES : k;
        for (int i = 1; i <= kk; i++) begin
            pos = (2 * i * nl + kk) / (2 * kk);
            m[pos-1] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fa.sv
// Single-bit full adder (3:2 counter) cell.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/pp_reduction_csa_level.sv
// One Wallace reduction level: N_IN rows of W2 bits compressed by 3:2
// counters into N_OUT rows, followed by a register (data + valid) that can
// be bypassed at runtime through `pipelined`.
module csa_level #(
    parameter int W2    = 16,
    parameter int N_IN  = 8,
    parameter int N_OUT = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipelined,
    input  logic                  in_valid,
    input  logic [N_IN*W2-1:0]    din,
    output logic                  out_valid,
    output logic [N_OUT*W2-1:0]   dout,
    output logic                  reg_valid
);

    localparam int GROUPS = N_IN / 3;
    localparam int REM    = N_IN % 3;

    logic [N_OUT*W2-1:0] red;
    logic [N_OUT*W2-1:0] dq;
    logic                vq;

    // Each group of three rows becomes a sum row and a carry row shifted
    // left by one; the carry out of the top column falls off (mod 2^W2).
    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        assign red[(2*g+1)*W2] = 1'b0;
        for (genvar k = 0; k < W2; k++) begin : g_bit
            if (k < W2 - 1) begin : g_fa
                fa u_fa (
                    .a   (din[(3*g)*W2 + k]),
                    .b   (din[(3*g+1)*W2 + k]),
                    .cin (din[(3*g+2)*W2 + k]),
                    .s   (red[(2*g)*W2 + k]),
                    .cout(red[(2*g+1)*W2 + k + 1])
                );
            end else begin : g_top
                assign red[(2*g)*W2 + k] = din[(3*g)*W2 + k] ^ din[(3*g+1)*W2 + k]
                                         ^ din[(3*g+2)*W2 + k];
            end
        end
    end

    for (genvar r = 0; r < REM; r++) begin : g_rem
        assign red[(2*GROUPS+r)*W2 +: W2] = din[(3*GROUPS+r)*W2 +: W2];
    end

    // Stage register: captures only real beats so idle cycles keep the last
    // (or reset) contents; the valid bit stays low while the level is bypassed.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            vq <= 1'b0;
            dq <= '0;
        end else begin
            vq <= pipelined & in_valid;
            if (pipelined && in_valid) begin
                dq <= red;
            end
        end
    end

    assign out_valid = pipelined ? vq : in_valid;
    assign dout      = pipelined ? dq : red;
    assign reg_valid = vq;

endmodule

// File: rtl/pp_reduction.sv
// Partial-product generation and Wallace carry-save reduction for the FMDSP
// multiplier. Produces two 2*WIDTH-bit vectors whose sum is a*b, with a
// runtime-selectable number (0..4) of registered reduction levels.
// Optional feature: define FMDSP_SIGNED_EN to add the `tc` port and
// Baugh-Wooley two's-complement handling.
module pp_reduction
    import fmdsp_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int PIPELINE_BITS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
`ifdef FMDSP_SIGNED_EN
    input  logic                     tc,
`endif
    input  logic [PIPELINE_BITS-1:0] pipes,
    output logic                     out_valid,
    output logic [2*WIDTH-1:0]       sum,
    output logic [2*WIDTH-1:0]       carry
);

    localparam int W2       = 2 * WIDTH;
    localparam int NL       = num_levels(WIDTH);
    localparam int BUS_W    = bus_offset(WIDTH, NL + 1);
    localparam int OFF_LAST = bus_offset(WIDTH, NL);

    typedef logic [NL-1:0] lvl_mask_t;

    localparam lvl_mask_t MASK_K1 = lvl_mask_t'(level_reg_mask(WIDTH, 1));
    localparam lvl_mask_t MASK_K2 = lvl_mask_t'(level_reg_mask(WIDTH, 2));
    localparam lvl_mask_t MASK_K3 = lvl_mask_t'(level_reg_mask(WIDTH, 3));
    localparam lvl_mask_t MASK_K4 = lvl_mask_t'(level_reg_mask(WIDTH, MAX_PIPES));

    logic [PIPELINE_BITS-1:0]  pipes_q;
    logic [PIPELINE_BITS-1:0]  pipes_sel;
    logic                      in_flight;
    lvl_mask_t                 lvl_en;
    lvl_mask_t                 lvl_reg_valid;
    logic [WIDTH-1:0][W2-1:0]  pp;
    logic [BUS_W-1:0]          bus;
    logic [NL:0]               vbus;

    // While beats are in flight the captured config holds; otherwise the
    // live `pipes` value applies to the beat entering this cycle.
    assign in_flight = |lvl_reg_valid;
    assign pipes_sel = in_flight ? pipes_q : pipes;

    // Config capture: track `pipes` whenever the pipeline is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipes_q <= '0;
        end else if (!in_flight) begin
            pipes_q <= pipes;
        end
    end

    // Select which reduction levels register, saturating the request at 4.
    always_comb begin
        // NOTE: default assignment first so no path leaves lvl_en unassigned
        // and no latch is inferred.
        lvl_en = '0;
        if (pipes_sel >= PIPELINE_BITS'(MAX_PIPES)) begin
            lvl_en = MASK_K4;
        end else if (pipes_sel == PIPELINE_BITS'(3)) begin
            lvl_en = MASK_K3;
        end else if (pipes_sel == PIPELINE_BITS'(2)) begin
            lvl_en = MASK_K2;
        end else if (pipes_sel == PIPELINE_BITS'(1)) begin
            lvl_en = MASK_K1;
        end
    end

    // AND-array partial products; in signed mode the cross terms involving
    // exactly one operand MSB are inverted and the two correction 1s are
    // folded into row 0, whose upper columns are otherwise empty. `tc` is
    // consumed here, so it rides through the pipeline encoded in the rows.
    always_comb begin
        pp = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
`ifdef FMDSP_SIGNED_EN
                pp[i][i+j] = (a[j] & b[i])
                           ^ (tc & ((i == WIDTH - 1) != (j == WIDTH - 1)));
`else
                pp[i][i+j] = a[j] & b[i];
`endif
            end
        end
`ifdef FMDSP_SIGNED_EN
        if (tc) begin
            pp[0][WIDTH]  = 1'b1;
            pp[0][W2-1]   = 1'b1;
        end
`endif
    end

    assign bus[0 +: WIDTH*W2] = pp;
    assign vbus[0]            = in_valid & ~rst;

    for (genvar j = 0; j < NL; j++) begin : g_lvl
        localparam int N_IN    = rows_at(WIDTH, j);
        localparam int N_OUT   = rows_at(WIDTH, j + 1);
        localparam int OFF_IN  = bus_offset(WIDTH, j);
        localparam int OFF_OUT = bus_offset(WIDTH, j + 1);

        csa_level #(
            .W2   (W2),
            .N_IN (N_IN),
            .N_OUT(N_OUT)
        ) u_lvl (
            .clk      (clk),
            .rst      (rst),
            .pipelined(lvl_en[j]),
            .in_valid (vbus[j]),
            .din      (bus[OFF_IN +: N_IN*W2]),
            .out_valid(vbus[j+1]),
            .dout     (bus[OFF_OUT +: N_OUT*W2]),
            .reg_valid(lvl_reg_valid[j])
        );
    end

    assign out_valid = vbus[NL];
    assign sum       = bus[OFF_LAST +: W2];
    assign carry     = bus[OFF_LAST + W2 +: W2];

endmodule

// File: tb/tb_pp_reduction.sv
// Scoreboard bench for pp_reduction (WIDTH=8): stimulus pushes the expected
// product and exit cycle, a monitor pops and compares on every out_valid.
module tb_pp_reduction;
    import fmdsp_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        tc;
    logic [2:0]  pipes;
    logic        out_valid;
    logic [15:0] sum;
    logic [15:0] carry;

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_pass;

    pp_reduction #(
        .WIDTH        (8),
        .PIPELINE_BITS(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
`ifdef FMDSP_SIGNED_EN
        .tc       (tc),
`endif
        .pipes    (pipes),
        .out_valid(out_valid),
        .sum      (sum),
        .carry    (carry)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a beat this cycle and record what must come out k cycles later.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic itc,
                         input int k, input logic [15:0] prod);
        exp_t e;
        a        = ia;
        b        = ib;
        tc       = itc;
        in_valid = 1'b1;
        e.prod   = prod;
        e.cyc    = cyc + k;
        sb.push_back(e);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (6) step();
    endtask

    // Monitor: compare every presented beat against the scoreboard head.
    initial begin
        exp_t        e;
        logic [15:0] tot;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                tot = sum + carry;
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("product", tot, e.prod);
                    check("exit_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        logic [5:0] m;
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        tc       = 1'b0;
        pipes    = 3'd0;

        // Shared register-placement table against hand values.
        m = level_reg_mask(8, 0); check("mask_k0", m, 6'b000000);
        m = level_reg_mask(8, 1); check("mask_k1", m, 6'b001000);
        m = level_reg_mask(8, 2); check("mask_k2", m, 6'b001010);
        m = level_reg_mask(8, 3); check("mask_k3", m, 6'b001101);
        check("levels_w8", num_levels(8), 4);
        check("levels_w16", num_levels(16), 6);

        step();
        step();
        rst = 1'b0;
        #1;
        check("reset_out_valid_k0", out_valid, 1'b0);

        // k=0: combinational, same-cycle exit.
        issue(8'd13, 8'd11, 1'b0, 0, 16'd143);
        step();
        drain();

        // k=2: three back-to-back beats, no bubbles.
        pipes = 3'd2;
        issue(8'd255, 8'd255, 1'b0, 2, 16'd65025);
        step();
        issue(8'd0, 8'd77, 1'b0, 2, 16'd0);
        step();
        issue(8'd128, 8'd2, 1'b0, 2, 16'd256);
        step();
        drain();

        // pipes=7 saturates to 4.
        pipes = 3'd7;
        issue(8'd200, 8'd100, 1'b0, 4, 16'd20000);
        step();
        drain();

        // Config change while a beat is in flight takes effect after drain.
        pipes = 3'd1;
        issue(8'd3, 8'd7, 1'b0, 1, 16'd21);
        step();
        in_valid = 1'b0;
        pipes    = 3'd3;
        step();
        issue(8'd12, 8'd12, 1'b0, 3, 16'd144);
        step();
        drain();

        // k=3 back-to-back.
        issue(8'd15, 8'd17, 1'b0, 3, 16'd255);
        step();
        issue(8'd255, 8'd1, 1'b0, 3, 16'd255);
        step();
        drain();

        // k=1 back-to-back.
        pipes = 3'd1;
        issue(8'd100, 8'd200, 1'b0, 1, 16'd20000);
        step();
        issue(8'd1, 8'd255, 1'b0, 1, 16'd255);
        step();
        issue(8'd255, 8'd255, 1'b0, 1, 16'd65025);
        step();
        drain();

        // Reset drops in-flight beats; beat offered during reset is ignored.
        pipes    = 3'd4;
        a        = 8'd50;
        b        = 8'd50;
        in_valid = 1'b1;
        step();
        a = 8'd60;
        step();
        rst = 1'b1;
        a   = 8'd1;
        b   = 8'd1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_reset_out_valid", out_valid, 1'b0);
        check("post_reset_sum", sum, 16'd0);
        check("post_reset_carry", carry, 16'd0);
        repeat (6) step();
        issue(8'd9, 8'd9, 1'b0, 4, 16'd81);
        step();
        drain();

`ifdef FMDSP_SIGNED_EN
        // Two's-complement operands.
        pipes = 3'd2;
        issue(8'hFD, 8'd5, 1'b1, 2, 16'hFFF1);
        step();
        issue(8'hFD, 8'd5, 1'b0, 2, 16'd1265);
        step();
        issue(8'h80, 8'h80, 1'b1, 2, 16'h4000);
        step();
        issue(8'd127, 8'hFF, 1'b1, 2, 16'hFF81);
        step();
        drain();
`endif

        in_valid = 1'b0;
        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            step();
        end
        check("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pp_reduction.md
# pp_reduction

Partial-product generation and carry-save reduction stage of the FMDSP multiplier, directly upstream of the final carry-propagate adder. It forms the WIDTH×WIDTH partial-product array, compresses it through a Wallace tree of 3:2 counters to two 2·WIDTH-bit vectors, and hands them to the final addition stage. It is runtime-pipelined: `pipes` selects how many reduction levels are registered, and a valid bit travels alongside each beat.

## Interface
- WIDTH, 8, operand width; legal values 8 and 16 (output vectors are 2·WIDTH)
- PIPELINE_BITS, 3, width of `pipes`
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  beat present on `a`/`b` this cycle
- a  in  WIDTH  multiplicand
- b  in  WIDTH  multiplier
- tc  in  1  two's-complement operands (only with FMDSP_SIGNED_EN)
- pipes  in  PIPELINE_BITS  requested register levels, 0..4; values above 4 act as 4
- out_valid  out  1  `sum`/`carry` hold a reduced beat
- sum  out  2·WIDTH  carry-save sum vector
- carry  out  2·WIDTH  carry-save carry vector, already aligned (no further shift)

## Operation
- Partial products: AND array, row i = (a & {WIDTH{b[i]}}) << i.
- Reduction: Wallace levels of 3:2 counters until two rows remain. NUM_LEVELS = 4 for WIDTH=8 (8→6→4→3→2), 6 for WIDTH=16 (16→11→8→6→4→3→2).
- Invariant: (sum + carry) mod 2^(2·WIDTH) == a·b.
- Register placement: k = min(pipes_eff, 4). Level j (1..NUM_LEVELS) is registered iff j == round(i·NUM_LEVELS/k) for some i in 1..k. For WIDTH=8: k=1 → {4}; k=2 → {2,4}; k=3 → {1,3,4}; k=4 → {1,2,3,4}. k=0 → fully combinational.
- Each enabled register level also registers the valid bit. Disabled levels pass data and valid through combinationally.
- Config capture: `pipes_q` loads `pipes` on every cycle in which no beat is in flight. A beat accepted on such a cycle uses the live `pipes` value. While any beat is in flight, `pipes` is ignored. The new value takes effect once the pipeline drains.
- No backpressure: one beat per cycle accepted unconditionally. Downstream must absorb every `out_valid`.
- `sum`/`carry` are don't-care when `out_valid`=0, but registered stages clear to 0 on reset.

## Timing
- Latency in_valid→out_valid = k cycles. k=0 is same-cycle, combinational.
- Throughput: 1 beat/cycle at any k. Back-to-back beats leave in order with no bubbles.
- Reset: on the edge with rst=1, all stage registers, valid bits and `pipes_q` clear to 0. `out_valid`=0 from the following cycle (and immediately when k=0 with in_valid=0).
- In-flight beats are dropped on reset. `in_valid` is ignored in the reset cycle.
- Combined multiplier latency = k + final-addition pipes. This block does not account for the downstream stage.

## Configuration
- FMDSP_SIGNED_EN defined:
  - `tc` port exists.
  - tc=1 applies Baugh-Wooley sign handling: MSB partial-product bits inverted, plus constant 1s at columns WIDTH and 2·WIDTH-1.
  - `tc` travels with the beat through the pipeline.
- FMDSP_SIGNED_EN undefined: no `tc` port; unsigned only; no sign-correction logic.

## Structure
- fmdsp_pkg:
  - MAX_PIPES = 4.
  - Function num_levels(WIDTH).
  - Function level_reg_mask(WIDTH, k), returning a NUM_LEVELS-bit enable mask shared with RTL and bench.
- Sub-module csa_level: one row of 3:2 compressors built from the existing `fa` cell, with an optional bypassable register (data + valid) controlled by a `pipelined` input. Instantiated NUM_LEVELS times.

## Test plan
- pipes=0, a=13, b=11, in_valid=1 → out_valid=1 same cycle, sum+carry=143.
- pipes=2, three back-to-back beats (255·255, 0·77, 128·2) → out_valid on cycles 2,3,4, with sums 65025, 0, 256.
- pipes=7 → treated as 4: a=200, b=100 → out_valid after exactly 4 cycles, sum+carry=20000.
- pipes=1, beat in flight, pipes switched to 3 in the next cycle → in-flight beat exits at latency 1. The next beat, issued after drain, exits at latency 3.
- pipes=4, two beats in flight, rst pulsed 1 cycle → out_valid never asserts for them; registered sum/carry read 0; a fresh beat afterwards has latency 4.
- FMDSP_SIGNED_EN, tc=1, a=8'hFD (-3), b=5 → sum+carry mod 2^16 = 16'hFFF1. With tc=0, the same operands → 1265.
